// File: rtl/ddr3_user_request_queue.sv
// ddr3_user_request_queue: valid/ready request FIFO feeding the DDR3 controller, with a strobe-timed read-tag pipe.
// Optional performance counters are enabled by defining DDR3_QUEUE_PERF_COUNTERS_EN.
module ddr3_user_request_queue #(
  parameter int QUEUE_DEPTH           = 8,
  parameter int DQ_BITWIDTH           = 16,
  parameter int ADDRESS_BITWIDTH      = 14,
  parameter int BANK_ADDRESS_BITWIDTH = 3,
  parameter int MAIN_STATE_BITWIDTH   = 5,
  parameter int STATE_WRITE_DATA      = 8,
  parameter int STATE_READ_DATA       = 11,
  parameter int READ_LATENCY_STROBES  = 6
) (
  input  logic                                              clk,
  input  logic                                              resetn,
  input  logic                                              req_valid,
  output logic                                              req_ready,
  input  logic                                              req_write,
  input  logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] req_address,
  input  logic [DQ_BITWIDTH-1:0]                            req_data,
  input  logic [MAIN_STATE_BITWIDTH-1:0]                    main_state,
  input  logic                                              clk_slow_posedge,
  input  logic                                              clk180_slow_posedge,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  output logic                                              rsp_valid,
  output logic [DQ_BITWIDTH-1:0]                            rsp_data,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] rsp_address,
  output logic [$clog2(QUEUE_DEPTH):0]                      queue_count
`ifdef DDR3_QUEUE_PERF_COUNTERS_EN
  ,
  output logic [15:0]                                       writes_issued,
  output logic [15:0]                                       reads_returned,
  output logic [15:0]                                       full_stall_cycles
`endif
);
  localparam int AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam int L  = READ_LATENCY_STROBES;
  typedef struct packed {
    logic                   wr;
    logic [AW-1:0]          addr;
    logic [DQ_BITWIDTH-1:0] data;
  } entry_t;
  entry_t                 mem_q [QUEUE_DEPTH];
  entry_t                 head;
  logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]          count_q, count_d;
  logic [L-1:0]           tag_v_q;
  logic [AW-1:0]          tag_a_q [L];
  logic                   we_q, re_q, rv_q;
  logic [AW-1:0]          addr_q, raddr_q;
  logic [DQ_BITWIDTH-1:0] data_q, rdata_q;
  logic                   strobe, empty, push, pop;
  assign head      = mem_q[rd_ptr_q];
  assign empty     = count_q == '0;
  assign strobe    = clk_slow_posedge | clk180_slow_posedge;
  assign req_ready = count_q != CW'(QUEUE_DEPTH);
  assign push      = req_valid & req_ready;
  // The head is only consumed when the controller is in the data state matching its type; no reordering.
  assign pop       = !empty & strobe & (head.wr ? main_state == MAIN_STATE_BITWIDTH'(STATE_WRITE_DATA)
                                                : main_state == MAIN_STATE_BITWIDTH'(STATE_READ_DATA));
  assign count_d   = count_q + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {req_write, req_address, req_data};
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tag_v_q  <= '0;
      for (int i = 0; i < L; i++) tag_a_q[i] <= '0;
      we_q     <= 1'b0;
      re_q     <= 1'b0;
      rv_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      raddr_q  <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(push);
      rd_ptr_q <= rd_ptr_q + PW'(pop);
      count_q  <= count_d;
      we_q     <= !empty & head.wr;
      re_q     <= !empty & !head.wr;
      if (!empty) begin
        addr_q <= head.addr;
        data_q <= head.data;
      end
      rv_q <= strobe & tag_v_q[L-1];
      if (strobe) begin
        if (tag_v_q[L-1]) begin
          rdata_q <= data_from_ram;
          raddr_q <= tag_a_q[L-1];
        end
        for (int i = L - 1; i > 0; i--) begin
          tag_v_q[i] <= tag_v_q[i-1];
          tag_a_q[i] <= tag_a_q[i-1];
        end
        tag_v_q[0] <= pop & !head.wr;
        tag_a_q[0] <= head.addr;
      end
    end
  assign write_enable        = we_q;
  assign read_enable         = re_q;
  assign i_user_data_address = addr_q;
  assign data_to_ram         = data_q;
  assign rsp_valid           = rv_q;
  assign rsp_data            = rdata_q;
  assign rsp_address         = raddr_q;
  assign queue_count         = count_q;
`ifdef DDR3_QUEUE_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      writes_issued     <= '0;
      reads_returned    <= '0;
      full_stall_cycles <= '0;
    end else begin
      if (pop & head.wr & ~&writes_issued) writes_issued <= writes_issued + 16'd1;
      if (rv_q & ~&reads_returned) reads_returned <= reads_returned + 16'd1;
      if (req_valid & ~req_ready & ~&full_stall_cycles) full_stall_cycles <= full_stall_cycles + 16'd1;
    end
`endif
endmodule

// File: tb/tb_ddr3_user_request_queue.sv
// tb_ddr3_user_request_queue: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ddr3_user_request_queue;
  localparam int D = 8, DQ = 16, A = 17, MSW = 5, L = 6, CW = $clog2(D) + 1;
  logic clk = 0, resetn = 0, req_valid = 0, req_write = 0, cs = 0, c180 = 0;
  logic [A-1:0] req_address = 0;
  logic [DQ-1:0] req_data = 0, data_from_ram = 0;
  logic [MSW-1:0] main_state = 0;
  logic req_ready, write_enable, read_enable, rsp_valid;
  logic [A-1:0] i_user_data_address, rsp_address;
  logic [DQ-1:0] data_to_ram, rsp_data;
  logic [CW-1:0] queue_count;
`ifdef DDR3_QUEUE_PERF_COUNTERS_EN
  logic [15:0] writes_issued, reads_returned, full_stall_cycles;
`endif
  always #5 clk = ~clk;
  ddr3_user_request_queue dut (
    .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data), .main_state(main_state),
    .clk_slow_posedge(cs), .clk180_slow_posedge(c180), .data_from_ram(data_from_ram),
    .write_enable(write_enable), .read_enable(read_enable), .i_user_data_address(i_user_data_address),
    .data_to_ram(data_to_ram), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_address(rsp_address),
    .queue_count(queue_count)
`ifdef DDR3_QUEUE_PERF_COUNTERS_EN
    , .writes_issued(writes_issued), .reads_returned(reads_returned), .full_stall_cycles(full_stall_cycles)
`endif
  );
  typedef struct { logic wr; logic [A-1:0] addr; logic [DQ-1:0] data; } req_t;
  typedef struct { logic [A-1:0] addr; int left; } tag_t;
  req_t mq[$];
  tag_t infl[$];
  logic [DQ-1:0] obs[$];
  logic m_we, m_re, m_rv, accepted = 0, record = 0;
  logic [A-1:0] m_addr, m_raddr, last_raddr = 0;
  logic [DQ-1:0] m_data, m_rdata;
  int m_wi, m_rr, m_fs;
  int errors = 0, checks = 0, cyc = 0, strb_every = 0, pulses = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    mq.delete(); infl.delete();
    m_we = 0; m_re = 0; m_rv = 0; m_addr = 0; m_data = 0; m_raddr = 0; m_rdata = 0;
    m_wi = 0; m_rr = 0; m_fs = 0;
  endfunction

  task automatic compare_all();
    check("req_ready", req_ready, mq.size() != D);
    check("queue_count", queue_count, mq.size());
    check("write_enable", write_enable, m_we);
    check("read_enable", read_enable, m_re);
    check("address", i_user_data_address, m_addr);
    check("data_to_ram", data_to_ram, m_data);
    check("rsp_valid", rsp_valid, m_rv);
    check("rsp_data", rsp_data, m_rdata);
    check("rsp_address", rsp_address, m_raddr);
`ifdef DDR3_QUEUE_PERF_COUNTERS_EN
    check("writes_issued", writes_issued, m_wi > 65535 ? 65535 : m_wi);
    check("reads_returned", reads_returned, m_rr > 65535 ? 65535 : m_rr);
    check("full_stall_cycles", full_stall_cycles, m_fs > 65535 ? 65535 : m_fs);
`endif
  endtask

  task automatic tick();
    logic st, ready, push, pop;
    cyc++;
    if (strb_every < 0) begin
      cs = $urandom_range(0, 2) == 0;
      c180 = $urandom_range(0, 3) == 0;
    end else begin
      cs = strb_every > 0 && cyc % strb_every == 0;
      c180 = 0;
    end
    data_from_ram = 16'($urandom);
    @(posedge clk);
    if (!resetn) begin
      model_reset();
      accepted = 0;
    end else begin
      st = cs | c180;
      ready = mq.size() != D;
      push = req_valid && ready;
      accepted = push;
      pop = mq.size() > 0 && st && (mq[0].wr ? main_state == 8 : main_state == 11);
      if (m_rv) m_rr++;
      if (req_valid && !ready) m_fs++;
      if (pop && mq[0].wr) m_wi++;
      m_rv = 0;
      if (mq.size() > 0) begin
        m_we = mq[0].wr; m_re = !mq[0].wr; m_addr = mq[0].addr; m_data = mq[0].data;
      end else begin
        m_we = 0; m_re = 0;
      end
      // Each read retires on the L-th strobe after the strobe that popped it.
      if (st) begin
        foreach (infl[i]) infl[i].left--;
        if (infl.size() > 0 && infl[0].left == 0) begin
          m_rv = 1; m_rdata = data_from_ram; m_raddr = infl[0].addr;
          void'(infl.pop_front());
        end
        if (pop && !mq[0].wr) infl.push_back('{mq[0].addr, L});
      end
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back('{req_write, req_address, req_data});
    end
    #1;
    compare_all();
    if (rsp_valid) begin pulses++; last_raddr = rsp_address; end
    if (record && write_enable && (obs.size() == 0 || obs[$] != data_to_ram)) obs.push_back(data_to_ram);
  endtask

  task automatic send(input logic wr, input logic [A-1:0] addr, input logic [DQ-1:0] data);
    req_valid = 1; req_write = wr; req_address = addr; req_data = data; accepted = 0;
    for (int n = 0; n < 200 && !accepted; n++) tick();
    check("send_accepted", accepted, 1);
    req_valid = 0;
  endtask

  task automatic drain();
    for (int n = 0; n < 400 && (queue_count != 0 || write_enable || read_enable); n++) tick();
    check("drain_count", queue_count, 0);
  endtask

  task automatic async_reset();
    #2 resetn = 0;
    model_reset();
    #1 compare_all();
    repeat (3) tick();
    resetn = 1;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    resetn = 1;
    #1 check("reset_ready", req_ready, 1);
    check("reset_count", queue_count, 0);
    // Idle with strobes and a data state active: nothing may be issued or returned.
    strb_every = -1; main_state = 8; pulses = 0;
    repeat (1000) tick();
    check("idle_pulses", pulses, 0);
    // Eight writes streamed out in order.
    strb_every = 2; record = 1; obs.delete();
    for (int i = 0; i < 8; i++) send(1, A'(i), 16'(16'h0100 + i * 16'h0101));
    drain();
    record = 0;
    check("wr_seq_len", obs.size(), 8);
    for (int i = 0; i < 8 && i < obs.size(); i++) check("wr_seq", obs[i], 16'(16'h0100 + i * 16'h0101));
    check("wr_we_low", write_enable, 0);
    check("wr_data_hold", data_to_ram, 16'h0807);
    // Fill to full with the controller parked; the ninth request must wait.
    main_state = 0;
    for (int i = 0; i < 8; i++) send(1, A'(16 + i), 16'(16'hA000 + i));
    req_valid = 1; req_write = 1; req_address = 99; req_data = 16'h9999; accepted = 0;
    repeat (5) tick();
    check("full_count", queue_count, 8);
    check("full_ready", req_ready, 0);
    check("full_held", accepted, 0);
    main_state = 8;
    for (int n = 0; n < 50 && !accepted; n++) tick();
    check("ninth_accepted", accepted, 1);
    req_valid = 0;
    drain();
    // Read behind a write: held until the read data state, then one response.
    send(1, 3, 16'hBEEF);
    send(0, 3, 0);
    for (int n = 0; n < 50 && !read_enable; n++) tick();
    check("read_at_head", read_enable, 1);
    check("read_queued", queue_count, 1);
    pulses = 0;
    main_state = 11;
    repeat (60) tick();
    check("read_pulses", pulses, 1);
    check("read_rsp_addr", last_raddr, 3);
    // Reset while reads are in flight: no response may follow.
    strb_every = 1;
    for (int i = 0; i < 3; i++) send(0, A'(10 + i), 0);
    repeat (2) tick();
    async_reset();
    check("rst_we", write_enable, 0);
    check("rst_rv", rsp_valid, 0);
    pulses = 0;
    repeat (30) tick();
    check("rst_pulses", pulses, 0);
    // Randomized mixed traffic with state changes and one reset in the middle.
    strb_every = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 37 == 0) main_state = MSW'(c % 3 == 0 ? 0 : ($urandom_range(0, 1) ? 8 : 11));
      if (accepted || !req_valid) begin
        req_valid = $urandom_range(0, 2) != 0;
        req_write = 1'($urandom_range(0, 1));
        req_address = A'($urandom);
        req_data = 16'($urandom);
        accepted = 0;
      end
      if (c == 1500) async_reset();
      tick();
    end
    req_valid = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
